// File: rtl/seq_pipe_elastic_en.sv
// Elastic val/rdy register pipeline with a global enable and synchronous flush.
// Empty stages absorb upstream data even while the output is stalled.
module seq_pipe_elastic_en #(
    parameter int NBITS   = 8,
    parameter int NSTAGES = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic                             clear,
    input  logic                             in_val,
    output logic                             in_rdy,
    input  logic [NBITS-1:0]                 in_msg,
    output logic                             out_val,
    input  logic                             out_rdy,
    output logic [NBITS-1:0]                 out_msg,
    output logic [$clog2(NSTAGES+1)-1:0]     count
);

    localparam int CW   = $clog2(NSTAGES + 1);
    localparam int LAST = NSTAGES - 1;

    logic [NSTAGES-1:0] v_q, v_d;
    logic [NSTAGES-1:0] rdy;
    logic [NBITS-1:0]   d_q [NSTAGES];
    logic [NBITS-1:0]   d_d [NSTAGES];
    logic [CW-1:0]      count_q, count_d;

    logic active;
    logic drain;
    logic xfer_in;
    logic xfer_out;

    always_comb begin
        // NOTE: combinational blocks use blocking '=' and give every output a
        // default first, so no path through the block can infer a latch.
        active    = en & ~clear;
        drain     = active & v_q[LAST] & out_rdy;
        rdy       = '0;
        rdy[LAST] = ~v_q[LAST] | drain;
        // Ready ripples from the output back toward the input through full stages.
        for (int k = NSTAGES - 2; k >= 0; k--) begin
            rdy[k] = ~v_q[k] | rdy[k + 1];
        end

        in_rdy   = active & rdy[0];
        out_val  = active & v_q[LAST];
        xfer_in  = in_val & in_rdy;
        xfer_out = out_val & out_rdy;
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (clear) begin
            v_d = '0;
        end else if (en) begin
            if (rdy[0]) begin
                v_d[0] = in_val;
                if (in_val) begin
                    d_d[0] = in_msg;
                end
            end
            for (int k = 1; k < NSTAGES; k++) begin
                if (rdy[k]) begin
                    v_d[k] = v_q[k - 1];
                    if (v_q[k - 1]) begin
                        d_d[k] = d_q[k - 1];
                    end
                end
            end
        end
    end

    always_comb begin
        if (clear) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(xfer_in) - CW'(xfer_out);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking '<='; the data array is reset here
        // too because the output message must read zero right after reset.
        if (reset) begin
            v_q     <= '0;
            count_q <= '0;
            for (int k = 0; k < NSTAGES; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
            d_q     <= d_d;
        end
    end

    assign out_msg = d_q[LAST];
    assign count   = count_q;

endmodule

// File: tb/tb_seq_pipe_elastic_en.sv
// Directed vector table plus hand-written corner sequences for the elastic pipe,
// followed by randomised FIFO-scoreboard runs on 32x5 and 1x1 configurations.
module tb_seq_pipe_elastic_en;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Directed DUT: NBITS=8, NSTAGES=3
    logic       reset, en, clear, in_val, in_rdy, out_val, out_rdy;
    logic [7:0] in_msg, out_msg;
    logic [1:0] count;

    seq_pipe_elastic_en #(.NBITS(8), .NSTAGES(3)) u_dut (
        .clk(clk), .reset(reset), .en(en), .clear(clear),
        .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
        .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .count(count)
    );

    // Random DUTs: index 0 is NBITS=32/NSTAGES=5, index 1 is NBITS=1/NSTAGES=1
    logic        r_reset, r_clear;
    logic [1:0]  r_en, r_in_val, r_in_rdy, r_out_val, r_out_rdy;
    logic [31:0] r_in_msg0, r_out_msg0;
    logic        r_in_msg1, r_out_msg1;
    logic [2:0]  r_cnt0;
    logic        r_cnt1;

    seq_pipe_elastic_en #(.NBITS(32), .NSTAGES(5)) u_rand0 (
        .clk(clk), .reset(r_reset), .en(r_en[0]), .clear(r_clear),
        .in_val(r_in_val[0]), .in_rdy(r_in_rdy[0]), .in_msg(r_in_msg0),
        .out_val(r_out_val[0]), .out_rdy(r_out_rdy[0]), .out_msg(r_out_msg0), .count(r_cnt0)
    );

    seq_pipe_elastic_en #(.NBITS(1), .NSTAGES(1)) u_rand1 (
        .clk(clk), .reset(r_reset), .en(r_en[1]), .clear(r_clear),
        .in_val(r_in_val[1]), .in_rdy(r_in_rdy[1]), .in_msg(r_in_msg1),
        .out_val(r_out_val[1]), .out_rdy(r_out_rdy[1]), .out_msg(r_out_msg1), .count(r_cnt1)
    );

    typedef struct {
        logic       iv;
        logic [7:0] msg;
        logic       ordy;
        logic       e_irdy;
        logic       e_oval;
        logic       chk_msg;
        logic [7:0] e_msg;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [7:0] msg, input logic ordy,
                       input logic e_irdy, input logic e_oval, input logic chk_msg,
                       input logic [7:0] e_msg, input logic [1:0] e_cnt);
        vec_t v;
        v.iv = iv; v.msg = msg; v.ordy = ordy;
        v.e_irdy = e_irdy; v.e_oval = e_oval; v.chk_msg = chk_msg;
        v.e_msg = e_msg; v.e_cnt = e_cnt;
        tbl.push_back(v);
    endtask

    // Drive one cycle of inputs at the falling edge and settle before sampling.
    task automatic step(input logic rst, input logic e, input logic c, input logic iv,
                        input logic [7:0] m, input logic ordy);
        @(negedge clk);
        reset = rst; en = e; clear = c; in_val = iv; in_msg = m; out_rdy = ordy;
        #1;
    endtask

    task automatic chk3(input string tag, input logic e_irdy, input logic e_oval,
                        input logic [1:0] e_cnt);
        check({tag, "_in_rdy"},  32'(in_rdy),  32'(e_irdy));
        check({tag, "_out_val"}, 32'(out_val), 32'(e_oval));
        check({tag, "_count"},   32'(count),   32'(e_cnt));
    endtask

    logic [31:0] sb [2][$];

    initial begin
        logic [7:0]  exp_list [2];
        int          idx;
        logic [31:0] act_cnt, act_msg, exp_rdy, mask;
        int          cap;

        reset = 1'b1; en = 1'b0; clear = 1'b0; in_val = 1'b0; in_msg = '0; out_rdy = 1'b0;
        r_reset = 1'b1; r_clear = 1'b0; r_en = '0; r_in_val = '0; r_out_rdy = '0;
        r_in_msg0 = '0; r_in_msg1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        r_reset = 1'b0;

        // Streaming at full rate, then output stall with a waiting producer,
        // then bubble collapse behind a stalled head.
        //   iv  msg    ordy irdy oval chk  e_msg  cnt
        add(1, 8'h11, 1,  1, 0, 1, 8'h00, 2'd0);
        add(1, 8'h22, 1,  1, 0, 0, 8'h00, 2'd1);
        add(1, 8'h33, 1,  1, 0, 0, 8'h00, 2'd2);
        add(1, 8'h44, 1,  1, 1, 1, 8'h11, 2'd3);
        add(0, 8'h00, 1,  1, 1, 1, 8'h22, 2'd3);
        add(0, 8'h00, 1,  1, 1, 1, 8'h33, 2'd2);
        add(0, 8'h00, 1,  1, 1, 1, 8'h44, 2'd1);
        add(0, 8'h00, 1,  1, 0, 0, 8'h00, 2'd0);
        add(1, 8'h0A, 0,  1, 0, 0, 8'h00, 2'd0);
        add(1, 8'h0B, 0,  1, 0, 0, 8'h00, 2'd1);
        add(1, 8'h0C, 0,  1, 0, 0, 8'h00, 2'd2);
        add(1, 8'h0D, 0,  0, 1, 1, 8'h0A, 2'd3);
        add(1, 8'h0D, 0,  0, 1, 1, 8'h0A, 2'd3);
        add(1, 8'h0D, 1,  1, 1, 1, 8'h0A, 2'd3);
        add(0, 8'h00, 1,  1, 1, 1, 8'h0B, 2'd3);
        add(0, 8'h00, 1,  1, 1, 1, 8'h0C, 2'd2);
        add(0, 8'h00, 1,  1, 1, 1, 8'h0D, 2'd1);
        add(0, 8'h00, 1,  1, 0, 0, 8'h00, 2'd0);
        add(1, 8'h55, 0,  1, 0, 0, 8'h00, 2'd0);
        add(0, 8'h00, 0,  1, 0, 0, 8'h00, 2'd1);
        add(0, 8'h00, 0,  1, 0, 0, 8'h00, 2'd1);
        add(1, 8'h66, 0,  1, 1, 1, 8'h55, 2'd1);
        add(0, 8'h00, 0,  1, 1, 1, 8'h55, 2'd2);
        add(0, 8'h00, 0,  1, 1, 1, 8'h55, 2'd2);
        add(0, 8'h00, 1,  1, 1, 1, 8'h55, 2'd2);
        add(0, 8'h00, 1,  1, 1, 1, 8'h66, 2'd1);
        add(0, 8'h00, 1,  1, 0, 0, 8'h00, 2'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(1'b0, 1'b1, 1'b0, tbl[i].iv, tbl[i].msg, tbl[i].ordy);
            chk3($sformatf("vec%0d", i), tbl[i].e_irdy, tbl[i].e_oval, tbl[i].e_cnt);
            if (tbl[i].chk_msg) begin
                check($sformatf("vec%0d_out_msg", i), 32'(out_msg), 32'(tbl[i].e_msg));
            end
        end

        // Global enable low freezes the pipe and blocks both handshakes.
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 8'hA3, 1'b1);
            chk3($sformatf("en_off%0d", i), 1'b0, 1'b0, 2'd2);
        end
        exp_list[0] = 8'hA1;
        exp_list[1] = 8'hA2;
        idx = 0;
        for (int i = 0; i < 8 && idx < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
            if (out_val) begin
                check($sformatf("en_resume_msg%0d", idx), 32'(out_msg), 32'(exp_list[idx]));
                idx++;
            end
        end
        check("en_resume_delivered", 32'(idx), 32'd2);

        // Flush of a full pipe while both sides are trying to transfer.
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hB1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hB2, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hB3, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'hEE, 1'b1);
        chk3("clear_cycle", 1'b0, 1'b0, 2'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk3("after_clear", 1'b1, 1'b0, 2'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
        check("push77_in_rdy", 32'(in_rdy), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
            check($sformatf("lat77_out_val_t%0d", i), 32'(out_val), (i == 3) ? 32'd1 : 32'd0);
        end
        check("lat77_out_msg", 32'(out_msg), 32'h77);

        // Reset dominates en=0 and clear=1 and zeroes the data path too.
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hC1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hC2, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1);
        check("pre_reset_count", 32'(count), 32'd2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk3("post_reset", 1'b1, 1'b0, 2'd0);
        check("post_reset_out_msg", 32'(out_msg), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hD1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hD2, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk3("restream_t2", 1'b1, 1'b0, 2'd2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        check("restream_out_val", 32'(out_val), 32'd1);
        check("restream_out_msg", 32'(out_msg), 32'hD1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        check("restream_out_msg2", 32'(out_msg), 32'hD2);
        en = 1'b0;

        // Randomised handshakes against a FIFO scoreboard per configuration.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                act_cnt = (i == 0) ? 32'(r_cnt0) : 32'(r_cnt1);
                check($sformatf("rand%0d_c%0d_count", i, c), act_cnt, 32'(sb[i].size()));
                r_en[i]      = ($urandom_range(0, 9) < 8);
                r_in_val[i]  = ($urandom_range(0, 9) < 6);
                r_out_rdy[i] = ($urandom_range(0, 1) == 1);
            end
            r_in_msg0 = $urandom;
            r_in_msg1 = 1'($urandom);
            #1;
            for (int i = 0; i < 2; i++) begin
                cap     = (i == 0) ? 5 : 1;
                mask    = (i == 0) ? 32'hFFFF_FFFF : 32'h1;
                exp_rdy = 32'(r_en[i] && ((sb[i].size() < cap) || r_out_rdy[i]));
                check($sformatf("rand%0d_c%0d_in_rdy", i, c), 32'(r_in_rdy[i]), exp_rdy);
                if (!r_en[i]) begin
                    check($sformatf("rand%0d_c%0d_frozen_out_val", i, c), 32'(r_out_val[i]), 32'd0);
                end
                if (r_out_val[i] && r_out_rdy[i]) begin
                    act_msg = (i == 0) ? r_out_msg0 : 32'(r_out_msg1);
                    if (sb[i].size() == 0) begin
                        check($sformatf("rand%0d_c%0d_spurious_out", i, c), 32'd1, 32'd0);
                    end else begin
                        check($sformatf("rand%0d_c%0d_out_msg", i, c), act_msg, sb[i][0]);
                        void'(sb[i].pop_front());
                    end
                end
                if (r_in_val[i] && r_in_rdy[i]) begin
                    sb[i].push_back(((i == 0) ? r_in_msg0 : 32'(r_in_msg1)) & mask);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_pipe_elastic_en.md
Name: seq_pipe_elastic_en

Overview:
Parametrised elastic register pipeline: NSTAGES stages of NBITS-bit enabled registers, each stage with a valid bit. Bubbles collapse, so any empty stage accepts from upstream even while the output is stalled. A global enable freezes the whole pipe, which generalises the single-bit enabled flop to width, depth and a val/rdy handshake. A synchronous clear flushes the pipe. Used as a configurable retiming/buffering stage between val/rdy producers and consumers.

Parameters:
NBITS, 8, message width in bits (>=1)
NSTAGES, 3, number of register stages, equal to capacity and to unloaded latency (>=1)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
en  input  1  global enable; 0 freezes all state and blocks both handshakes
clear  input  1  synchronous flush of all stages
in_val  input  1  producer message valid
in_rdy  output  1  pipe can accept this cycle
in_msg  input  NBITS  producer message
out_val  output  1  message valid at output
out_rdy  input  1  consumer ready
out_msg  output  NBITS  output message (stage NSTAGES-1 data)
count  output  $clog2(NSTAGES+1)  number of valid stages

Behaviour:
- State: v[k], d[k] for k=0..NSTAGES-1. Stage 0 is the input side; stage NSTAGES-1 is the output.
- reset=1 at posedge: all v<=0, all d<=0. Reset dominates en and clear. The cycle after reset: out_val=0, count=0, out_msg=0, in_rdy=en&~clear.
- drain = en & ~clear & v[N-1] & out_rdy.
- rdy[N-1] = ~v[N-1] | drain. For k<N-1: rdy[k] = ~v[k] | (v[k] & rdy[k+1]). This is a combinational chain, and the path from out_rdy to in_rdy is permitted.
- in_rdy = en & ~clear & rdy[0]. out_val = en & ~clear & v[N-1]. out_msg = d[N-1] always, which is don't-care when out_val=0.
- Transfer in = in_val & in_rdy. Transfer out = out_val & out_rdy.
- Posedge with en=1, clear=0, reset=0, for each k with rdy[k]=1:
  - v[0] <= in_val, and d[0] <= in_msg if in_val.
  - v[k] <= v[k-1], and d[k] <= d[k-1] if v[k-1].
- Stages with rdy[k]=0 hold.
- en=0: all state holds and no transfer occurs in either direction. in_val and out_rdy are ignored.
- clear=1 (en=1 or 0, reset=0): all v<=0 at posedge, and d holds. in_rdy=0 and out_val=0 during the clear cycle, so nothing is accepted or delivered.
- Latency: a message accepted in cycle t is at the output (out_val=1) in cycle t+NSTAGES if unstalled. Throughput is 1 msg/cycle.
- Full (count=NSTAGES): in_rdy = en & ~clear & out_rdy. Simultaneous in/out transfer keeps count unchanged.
- Empty: out_val=0. A message never bypasses the registers; minimum latency is NSTAGES.
- count: registered popcount of v, updated consistently with v (+1 on in-only, -1 on out-only, 0 on both or neither). It is 0 after reset or clear.
- Ordering: strict FIFO order, with no loss or duplication under any en/out_rdy pattern.
- NSTAGES=1 degenerates to a single enabled register with val/rdy.

Test Plan:
1. Reset, then stream 0x11,0x22,0x33,0x44 with en=1 and out_rdy=1 held -> out_val rises 3 cycles after 0x11 is accepted; outputs are 0x11..0x44 on consecutive cycles; count peaks at 3.
2. out_rdy=0, push 0x0A,0x0B,0x0C,0x0D -> first three are accepted; in_rdy=0 once count=3; 0x0D waits. Raise out_rdy -> 0x0A leaves and 0x0D is accepted in the same cycle; count stays 3.
3. Bubble collapse: push 0x55, idle 2 cycles, push 0x66 with out_rdy=0 -> both sit in stages 2 and 1 with no gap; count=2. Releasing out_rdy delivers 0x55 then 0x66 back-to-back.
4. en=0 for 4 cycles with the pipe holding 0xA1,0xA2 and in_val=1, out_rdy=1 -> in_rdy=0, out_val=0, count unchanged. en=1 resumes in order with no loss.
5. Pipe full, assert clear with in_val=1 and out_rdy=1 -> in_rdy=0 and out_val=0 that cycle. Next cycle count=0 and out_val=0. A later push of 0x77 emerges after 3 cycles.
6. Assert reset mid-stream with count=2 and en=0, clear=1 -> next cycle v all 0, count=0, out_msg=0. A subsequent stream behaves as in test 1. Also run randomised en/in_val/out_rdy against a FIFO scoreboard with NSTAGES=1 and NSTAGES=5, NBITS=1 and NBITS=32.
